// File: rtl/alu_2020.sv
// alu_2020: XLEN-bit integer ALU (add/sub, logic, shifts, compares, pass-b).
// Produces result s, NZVC flags and an illegal-opcode flag (hata).
// The combinational core can be wrapped by an optional input register
// stage (IN_REG) and an optional output register stage (OUT_REG).
// Optional feature macro: ALU2020_STICKY_ERR_EN makes hata sticky until rst_n.
module alu_2020 #(
    parameter int XLEN    = 32,
    parameter int IN_REG  = 0,
    parameter int OUT_REG = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] s,
    output logic            n,
    output logic            z,
    output logic            v,
    output logic            c,
    output logic            hata
);

    localparam int SW = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOR   = 4'b0101,
        OP_SLL   = 4'b0110,
        OP_SRL   = 4'b0111,
        OP_SRA   = 4'b1000,
        OP_SLT   = 4'b1001,
        OP_SLTU  = 4'b1010,
        OP_PASSB = 4'b1011
    } alu_op_e;

    // ------------------------------------------------------------------
    // Input stage: the flops exist in every build; the mux below selects
    // them only when IN_REG is set, so with IN_REG=0 they are dead logic.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [3:0]      op_r;

    logic [XLEN-1:0] a_s;
    logic [XLEN-1:0] b_s;
    logic [3:0]      op_s;

    // Input register stage: loads every edge, clears to ADD 0+0 on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            op_r <= 4'b0000;
        end else begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op;
        end
    end

    // Select registered or direct operands for the core
    always_comb begin
        a_s  = a;
        b_s  = b;
        op_s = op;
        if (IN_REG != 0) begin
            a_s  = a_r;
            b_s  = b_r;
            op_s = op_r;
        end else begin
            a_s  = a;
            b_s  = b;
            op_s = op;
        end
    end

    // ------------------------------------------------------------------
    // Combinational core
    // ------------------------------------------------------------------
    logic [SW-1:0]   shamt_s;
    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   diff_s;
    logic [XLEN:0]   shl_s;
    logic [XLEN:0]   shr_s;
    logic [XLEN:0]   sra_s;
    logic            lt_s;
    logic            ltu_s;

    logic [XLEN-1:0] res_s;
    logic            c_core_s;
    logic            v_core_s;
    logic            ill_s;
    logic            n_core_s;
    logic            z_core_s;

    assign shamt_s = b_s[SW-1:0];

    // Shared datapath terms. The shifters carry one extra bit so the last
    // bit shifted out falls into bit XLEN (left) or bit 0 (right); with a
    // zero shift amount that extra bit is the padding zero, giving c=0.
    always_comb begin
        sum_s  = {1'b0, a_s} + {1'b0, b_s};
        diff_s = {1'b0, a_s} + {1'b0, ~b_s} + {{XLEN{1'b0}}, 1'b1};
        shl_s  = {1'b0, a_s} << shamt_s;
        shr_s  = {a_s, 1'b0} >> shamt_s;
        sra_s  = $signed({a_s, 1'b0}) >>> shamt_s;
        lt_s   = $signed(a_s) < $signed(b_s);
        ltu_s  = a_s < b_s;
    end

    // Operation decode: result, carry, overflow and illegal flag
    always_comb begin
        res_s    = '0;
        c_core_s = 1'b0;
        v_core_s = 1'b0;
        ill_s    = 1'b0;
        case (op_s)
            OP_ADD: begin
                res_s    = sum_s[XLEN-1:0];
                c_core_s = sum_s[XLEN];
                v_core_s = (a_s[XLEN-1] == b_s[XLEN-1]) &&
                           (sum_s[XLEN-1] != a_s[XLEN-1]);
            end
            OP_SUB: begin
                res_s    = diff_s[XLEN-1:0];
                c_core_s = diff_s[XLEN];
                v_core_s = (a_s[XLEN-1] != b_s[XLEN-1]) &&
                           (diff_s[XLEN-1] != a_s[XLEN-1]);
            end
            OP_AND:   res_s = a_s & b_s;
            OP_OR:    res_s = a_s | b_s;
            OP_XOR:   res_s = a_s ^ b_s;
            OP_NOR:   res_s = ~(a_s | b_s);
            OP_SLL: begin
                res_s    = shl_s[XLEN-1:0];
                c_core_s = shl_s[XLEN];
            end
            OP_SRL: begin
                res_s    = shr_s[XLEN:1];
                c_core_s = shr_s[0];
            end
            OP_SRA: begin
                res_s    = sra_s[XLEN:1];
                c_core_s = sra_s[0];
            end
            OP_SLT:   res_s = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU:  res_s = {{(XLEN-1){1'b0}}, ltu_s};
            OP_PASSB: res_s = b_s;
            default: begin
                res_s    = '0;
                c_core_s = 1'b0;
                v_core_s = 1'b0;
                ill_s    = 1'b1;
            end
        endcase
    end

    // N and Z follow the final result, but are forced low for illegal ops
    always_comb begin
        n_core_s = res_s[XLEN-1] & ~ill_s;
        z_core_s = (res_s == '0) & ~ill_s;
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic [XLEN-1:0] s_r;
    logic            n_r;
    logic            z_r;
    logic            v_r;
    logic            c_r;
    logic            ill_r;

    logic [XLEN-1:0] s_stg_s;
    logic            n_stg_s;
    logic            z_stg_s;
    logic            v_stg_s;
    logic            c_stg_s;
    logic            ill_stg_s;

    // Output register stage: loads every edge, clears to all-zero on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r   <= '0;
            n_r   <= 1'b0;
            z_r   <= 1'b0;
            v_r   <= 1'b0;
            c_r   <= 1'b0;
            ill_r <= 1'b0;
        end else begin
            s_r   <= res_s;
            n_r   <= n_core_s;
            z_r   <= z_core_s;
            v_r   <= v_core_s;
            c_r   <= c_core_s;
            ill_r <= ill_s;
        end
    end

    // Select registered or direct core results
    always_comb begin
        s_stg_s   = res_s;
        n_stg_s   = n_core_s;
        z_stg_s   = z_core_s;
        v_stg_s   = v_core_s;
        c_stg_s   = c_core_s;
        ill_stg_s = ill_s;
        if (OUT_REG != 0) begin
            s_stg_s   = s_r;
            n_stg_s   = n_r;
            z_stg_s   = z_r;
            v_stg_s   = v_r;
            c_stg_s   = c_r;
            ill_stg_s = ill_r;
        end else begin
            s_stg_s   = res_s;
            n_stg_s   = n_core_s;
            z_stg_s   = z_core_s;
            v_stg_s   = v_core_s;
            c_stg_s   = c_core_s;
            ill_stg_s = ill_s;
        end
    end

    assign s = s_stg_s;
    assign n = n_stg_s;
    assign z = z_stg_s;
    assign v = v_stg_s;
    assign c = c_stg_s;

`ifdef ALU2020_STICKY_ERR_EN
    logic err_r;

    // Sticky error flop: set by a stage-aligned illegal op, cleared only by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (ill_stg_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign hata = err_r | ill_stg_s;
`else
    assign hata = ill_stg_s;
`endif

endmodule

// File: tb/tb_alu_2020.sv
// Self-checking bench for alu_2020: one combinational instance and one
// instance with both register stages, checked against a behavioural model.
module tb_alu_2020;

`ifdef ALU2020_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] s;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
        logic        ill;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_c, b_c, a_p, b_p;
    logic [3:0]  op_c, op_p;
    logic [31:0] s_c, s_p;
    logic        n_c, z_c, v_c, c_c, hata_c;
    logic        n_p, z_p, v_p, c_p, hata_p;

    int total;
    int bad;
    bit seen_c;
    bit seen_p;

    alu_2020 #(.XLEN(32), .IN_REG(0), .OUT_REG(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .a(a_c), .b(b_c), .op(op_c),
        .s(s_c), .n(n_c), .z(z_c), .v(v_c), .c(c_c), .hata(hata_c)
    );

    alu_2020 #(.XLEN(32), .IN_REG(1), .OUT_REG(1)) u_pipe (
        .clk(clk), .rst_n(rst_n), .a(a_p), .b(b_p), .op(op_p),
        .s(s_p), .n(n_p), .z(z_p), .v(v_p), .c(c_p), .hata(hata_p)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Behavioural reference: plain arithmetic and bit-by-bit shifting
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op);
        res_t r;
        longint sv;
        logic [63:0] wide;
        int sh;
        r = '0;
        sh = int'(b[4:0]);
        case (op)
            4'd0: begin
                wide = {32'd0, a} + {32'd0, b};
                r.s = wide[31:0];
                r.c = wide[32];
                sv = longint'($signed(a)) + longint'($signed(b));
                r.v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            end
            4'd1: begin
                r.s = a - b;
                r.c = (a >= b);
                sv = longint'($signed(a)) - longint'($signed(b));
                r.v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            end
            4'd2: r.s = a & b;
            4'd3: r.s = a | b;
            4'd4: r.s = a ^ b;
            4'd5: r.s = ~(a | b);
            4'd6: begin
                r.s = a;
                for (int i = 0; i < sh; i++) begin
                    r.c = r.s[31];
                    r.s = {r.s[30:0], 1'b0};
                end
            end
            4'd7: begin
                r.s = a;
                for (int i = 0; i < sh; i++) begin
                    r.c = r.s[0];
                    r.s = {1'b0, r.s[31:1]};
                end
            end
            4'd8: begin
                r.s = a;
                for (int i = 0; i < sh; i++) begin
                    r.c = r.s[0];
                    r.s = {r.s[31], r.s[31:1]};
                end
            end
            4'd9:  r.s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10: r.s = (a < b) ? 32'd1 : 32'd0;
            4'd11: r.s = b;
            default: r.ill = 1'b1;
        endcase
        if (!r.ill) begin
            r.n = r.s[31];
            r.z = (r.s == 32'd0);
        end
        return r;
    endfunction

    task automatic test_reset();
        #5;
        total++;
        if ({s_p, n_p, z_p, v_p, c_p, hata_p} !== 37'd0) begin
            bad++;
            $display("FAIL reset_pipe: got s=%h nzvc=%b%b%b%b hata=%b, want all zero",
                     s_p, n_p, z_p, v_p, c_p, hata_p);
        end
        total++;
        if ({s_c, n_c, z_c, v_c, c_c, hata_c} !== {32'd0, 5'b01000}) begin
            bad++;
            $display("FAIL reset_comb: got s=%h nzvc=%b%b%b%b hata=%b, want s=0 nzvc=0100 hata=0",
                     s_c, n_c, z_c, v_c, c_c, hata_c);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #10;
        // First edge after release: output stage shows ADD 0+0 from cleared input regs
        total++;
        if ({s_p, n_p, z_p, v_p, c_p, hata_p} !== {32'd0, 5'b01000}) begin
            bad++;
            $display("FAIL reset_release: got s=%h nzvc=%b%b%b%b hata=%b, want s=0 nzvc=0100",
                     s_p, n_p, z_p, v_p, c_p, hata_p);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd3,
                                 32'h80000001, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h12345678, 32'd0};
        logic [31:0] vb [11] = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd5, 32'd4, 32'd1, 32'd1,
                                 32'd1, 32'd0, 32'd0};
        logic [3:0]  vo [11] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd8, 4'd6, 4'd9, 4'd10,
                                 4'd7, 4'd15};
        logic [31:0] es [11] = '{32'h80000000, 32'd0, 32'd0, 32'h7FFFFFFF, 32'hFFFFFFFE,
                                 32'hF8000000, 32'd0, 32'd1, 32'd0, 32'h12345678, 32'd0};
        logic [3:0]  ef [11] = '{4'b1010, 4'b0101, 4'b0101, 4'b0011, 4'b1000, 4'b1000,
                                 4'b0101, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        logic        eh [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #2;
            a_c = va[i]; b_c = vb[i]; op_c = vo[i];
            #10;
            total++;
            if ({s_c, n_c, z_c, v_c, c_c, hata_c} !== {es[i], ef[i], eh[i]}) begin
                bad++;
                $display("FAIL vector_%0d: got s=%h nzvc=%b%b%b%b hata=%b, want s=%h nzvc=%b hata=%b",
                         i, s_c, n_c, z_c, v_c, c_c, hata_c, es[i], ef[i], eh[i]);
            end
            if (eh[i] && STICKY) seen_c = 1'b1;
        end
    endtask

    task automatic test_random();
        res_t e;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            a_c  = $urandom();
            b_c  = (i % 4 == 0) ? 32'($urandom_range(0, 33)) : $urandom();
            op_c = 4'($urandom_range(0, 15));
            if (i % 5 == 0) a_c = {a_c[31], 31'h7FFFFFFF} ^ {1'b0, {31{a_c[0]}}};
            e = model(a_c, b_c, op_c);
            #10;
            total++;
            if ({s_c, n_c, z_c, v_c, c_c, hata_c} !== {e.s, e.n, e.z, e.v, e.c, e.ill | seen_c}) begin
                bad++;
                $display("FAIL random_%0d op=%h a=%h b=%h: got s=%h nzvc=%b%b%b%b hata=%b, want s=%h nzvc=%b%b%b%b hata=%b",
                         i, op_c, a_c, b_c, s_c, n_c, z_c, v_c, c_c, hata_c,
                         e.s, e.n, e.z, e.v, e.c, e.ill | seen_c);
            end
            if (e.ill && STICKY) seen_c = 1'b1;
        end
    endtask

    task automatic test_pipeline_latency();
        @(posedge clk); #2;
        a_p = 32'd0; b_p = 32'd0; op_p = 4'd0;
        @(posedge clk); @(posedge clk); #2;
        a_p = 32'd2; b_p = 32'd3; op_p = 4'd0;
        #10;
        total++;
        if (s_p !== 32'd0) begin
            bad++;
            $display("FAIL latency_edge0: got s=%h, want 00000000", s_p);
        end
        @(posedge clk); #10;
        total++;
        if (s_p !== 32'd0) begin
            bad++;
            $display("FAIL latency_edge1: got s=%h, want 00000000", s_p);
        end
        @(posedge clk); #10;
        total++;
        if ({s_p, n_p, z_p, v_p, c_p} !== {32'd5, 4'b0000}) begin
            bad++;
            $display("FAIL latency_edge2: got s=%h nzvc=%b%b%b%b, want s=00000005 nzvc=0000",
                     s_p, n_p, z_p, v_p, c_p);
        end
    endtask

    task automatic test_back_to_back();
        res_t q[$];
        res_t e;
        q.push_back(model(32'd2, 32'd3, 4'd0));
        q.push_back(model(32'd2, 32'd3, 4'd0));
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #2;
            a_p  = $urandom();
            b_p  = (i % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom();
            op_p = 4'($urandom_range(0, 15));
            q.push_back(model(a_p, b_p, op_p));
            #10;
            e = q.pop_front();
            total++;
            if ({s_p, n_p, z_p, v_p, c_p, hata_p} !== {e.s, e.n, e.z, e.v, e.c, e.ill | seen_p}) begin
                bad++;
                $display("FAIL b2b_%0d: got s=%h nzvc=%b%b%b%b hata=%b, want s=%h nzvc=%b%b%b%b hata=%b",
                         i, s_p, n_p, z_p, v_p, c_p, hata_p,
                         e.s, e.n, e.z, e.v, e.c, e.ill | seen_p);
            end
            if (e.ill && STICKY) seen_p = 1'b1;
        end
    endtask

    task automatic test_midflight_reset();
        @(posedge clk); #2;
        a_p = 32'd7; b_p = 32'd8; op_p = 4'd0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        seen_p = 1'b0;
        seen_c = 1'b0;
        #1;
        total++;
        if ({s_p, n_p, z_p, v_p, c_p, hata_p} !== 37'd0) begin
            bad++;
            $display("FAIL midflight_in_reset: got s=%h nzvc=%b%b%b%b hata=%b, want all zero",
                     s_p, n_p, z_p, v_p, c_p, hata_p);
        end
        a_p = 32'd1; b_p = 32'd1; op_p = 4'd0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #10;
        total++;
        if ({s_p, n_p, z_p, v_p, c_p, hata_p} !== {32'd0, 5'b01000}) begin
            bad++;
            $display("FAIL midflight_edge1: got s=%h nzvc=%b%b%b%b hata=%b, want s=0 nzvc=0100",
                     s_p, n_p, z_p, v_p, c_p, hata_p);
        end
        @(posedge clk); #10;
        total++;
        if ({s_p, n_p, z_p, v_p, c_p, hata_p} !== {32'd2, 5'b00000}) begin
            bad++;
            $display("FAIL midflight_edge2: got s=%h nzvc=%b%b%b%b hata=%b, want s=00000002 nzvc=0000",
                     s_p, n_p, z_p, v_p, c_p, hata_p);
        end
    endtask

    task automatic test_sticky();
        @(posedge clk); #2;
        a_c = 32'd1; b_c = 32'd1; op_c = 4'd0;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        op_c = 4'b1111;
        #10;
        total++;
        if ({s_c, hata_c} !== {32'd0, 1'b1}) begin
            bad++;
            $display("FAIL sticky_illegal: got s=%h hata=%b, want s=0 hata=1", s_c, hata_c);
        end
        @(posedge clk); #2;
        op_c = 4'd0;
        #10;
        total++;
        if ({s_c, n_c, z_c, v_c, c_c, hata_c} !== {32'd2, 4'b0000, STICKY}) begin
            bad++;
            $display("FAIL sticky_after_legal: got s=%h nzvc=%b%b%b%b hata=%b, want s=00000002 nzvc=0000 hata=%b",
                     s_c, n_c, z_c, v_c, c_c, hata_c, STICKY);
        end
        @(posedge clk); #10;
        total++;
        if (hata_c !== STICKY) begin
            bad++;
            $display("FAIL sticky_hold: got hata=%b, want %b", hata_c, STICKY);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (hata_c !== 1'b0) begin
            bad++;
            $display("FAIL sticky_cleared: got hata=%b, want 0", hata_c);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        seen_c = 1'b0;
        seen_p = 1'b0;
        rst_n = 1'b0;
        a_c = 32'd0; b_c = 32'd0; op_c = 4'd0;
        a_p = 32'd0; b_p = 32'd0; op_p = 4'd0;
        test_reset();
        test_vectors();
        test_random();
        test_pipeline_latency();
        test_back_to_back();
        test_midflight_reset();
        test_sticky();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
